// File: rtl/snn_input_loader.sv
// snn_input_loader: unpacks UART bytes into single-bit pixel writes for the
// 784 x 1 input RAM, then hands the RAM address mux to snn_core and pulses
// its start once a full image has been stored.
module snn_input_loader #(
  parameter int NUM_BITS = 784,
  parameter int ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rx_rdy,
  input  logic [7:0]        i_rx_data,
  input  logic [ADDR_W-1:0] i_core_addr,
  input  logic              i_core_done,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_data,
  output logic              o_core_start,
  output logic              o_busy,
  output logic              o_overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_START = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Address of the final pixel; writing it completes the frame.
  localparam logic [ADDR_W-1:0] LP_LAST_PIX = ADDR_W'(NUM_BITS - 1);

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pix_cnt, w_pix_cnt_nxt;
  logic [2:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic              r_hold_vld, w_hold_vld_nxt;
  logic              r_overrun, w_overrun_nxt;
  logic [7:0]        r_sh, w_sh_nxt;
  logic [7:0]        r_hold, w_hold_nxt;

  // Next-state, datapath and output decode for the load/start/run sequence.
  always_comb begin
    w_state_nxt    = r_state;
    w_pix_cnt_nxt  = r_pix_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_hold_vld_nxt = r_hold_vld;
    w_overrun_nxt  = r_overrun;
    w_sh_nxt       = r_sh;
    w_hold_nxt     = r_hold;
    o_ram_we       = 1'b0;
    o_ram_data     = 1'b0;
    o_core_start   = 1'b0;
    o_ram_addr     = r_pix_cnt;

    case (r_state)
      S_IDLE: begin
        if (i_rx_rdy) begin
          w_sh_nxt      = i_rx_data;
          w_bit_cnt_nxt = 3'd0;
          w_state_nxt   = S_WRITE;
          // First byte of a fresh frame starts a clean overrun history.
          if (r_pix_cnt == '0) w_overrun_nxt = 1'b0;
        end
      end

      S_WRITE: begin
        o_ram_we      = 1'b1;
        o_ram_data    = r_sh[0];
        w_sh_nxt      = {1'b0, r_sh[7:1]};
        w_pix_cnt_nxt = r_pix_cnt + 1'b1;
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (r_bit_cnt == 3'd7) begin
          if (r_pix_cnt == LP_LAST_PIX) begin
            // Frame complete: anything queued or arriving now belongs to no
            // frame the core can accept, so it is dropped.
            w_state_nxt    = S_START;
            w_hold_vld_nxt = 1'b0;
            if (r_hold_vld || i_rx_rdy) w_overrun_nxt = 1'b1;
          end else if (r_hold_vld) begin
            // Consume the held byte with no bubble; a coincident byte refills hold.
            w_sh_nxt = r_hold;
            if (i_rx_rdy) begin
              w_hold_nxt     = i_rx_data;
              w_hold_vld_nxt = 1'b1;
            end else begin
              w_hold_vld_nxt = 1'b0;
            end
          end else if (i_rx_rdy) begin
            // Byte arriving on the last bit goes straight into the shifter.
            w_sh_nxt = i_rx_data;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (i_rx_rdy) begin
          if (!r_hold_vld) begin
            w_hold_nxt     = i_rx_data;
            w_hold_vld_nxt = 1'b1;
          end else begin
            w_overrun_nxt = 1'b1;
          end
        end
      end

      S_START: begin
        o_core_start  = 1'b1;
        o_ram_addr    = i_core_addr;
        w_pix_cnt_nxt = '0;
        w_state_nxt   = S_RUN;
        if (i_rx_rdy) w_overrun_nxt = 1'b1;
      end

      S_RUN: begin
        o_ram_addr = i_core_addr;
        if (i_rx_rdy) w_overrun_nxt = 1'b1;
        if (i_core_done) w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy    = (r_pix_cnt != '0) || (r_state != S_IDLE);
  assign o_overrun = r_overrun;

  // Control state with asynchronous reset; reset abandons any partial frame.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_pix_cnt  <= '0;
      r_bit_cnt  <= 3'd0;
      r_hold_vld <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pix_cnt  <= w_pix_cnt_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_hold_vld <= w_hold_vld_nxt;
      r_overrun  <= w_overrun_nxt;
    end
  end

  // Byte shifter and hold buffer; contents only matter while qualified by control.
  always_ff @(posedge i_clk) begin
    r_sh   <= w_sh_nxt;
    r_hold <= w_hold_nxt;
  end

endmodule

// File: tb/tb_snn_input_loader.sv
// Self-checking bench for snn_input_loader: a queue-based pixel model is
// compared against the DUT outputs on every falling clock edge.
module tb_snn_input_loader;
  localparam int NUM_BITS = 784;
  localparam int ADDR_W   = 10;
  localparam int NBYTES   = NUM_BITS / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic [ADDR_W-1:0] core_addr = '0;
  logic              core_done = 1'b0;
  logic              ram_we, ram_data, core_start, busy, overrun;
  logic [ADDR_W-1:0] ram_addr;

  snn_input_loader #(.NUM_BITS(NUM_BITS), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_rdy(rx_rdy), .i_rx_data(rx_data),
    .i_core_addr(core_addr), .i_core_done(core_done),
    .o_ram_we(ram_we), .o_ram_addr(ram_addr), .o_ram_data(ram_data),
    .o_core_start(core_start), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural model: pixels still to be written, frame position, phase.
  bit   q[$];
  int   m_pix   = 0;
  int   m_phase = 0;   // 0 loading, 1 start cycle, 2 core running
  bit   m_ov    = 0;

  // Observed DUT activity used by directed checks.
  int   cyc = 0;
  int   we_cnt = 0;
  int   start_cnt = 0;
  int   last_rx_cyc = 0;
  int   start_cyc = 0;
  bit   tb_mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: outputs against the model, then advance the model.
  always @(negedge clk) begin
    int e_we, e_addr, e_data, e_start, e_busy, sz;
    if (rst) begin
      q.delete(); m_pix = 0; m_phase = 0; m_ov = 0;
      check("rst_we", ram_we, 0);
      check("rst_addr", ram_addr, 0);
      check("rst_start", core_start, 0);
      check("rst_busy", busy, 0);
      check("rst_ovr", overrun, 0);
    end else begin
      e_we = 0; e_addr = m_pix; e_data = 0; e_start = 0; e_busy = 1;
      if (m_phase == 0) begin
        e_we   = (q.size() > 0);
        e_data = (q.size() > 0) ? int'(q[0]) : 0;
        e_busy = (m_pix != 0 || q.size() != 0);
      end else begin
        e_addr  = core_addr;
        e_start = (m_phase == 1);
      end
      check("we", ram_we, e_we);
      check("addr", ram_addr, e_addr);
      if (e_we) check("data", ram_data, e_data);
      check("start", core_start, e_start);
      check("busy", busy, e_busy);
      check("overrun", overrun, m_ov);

      if (ram_we) begin tb_mem[ram_addr] = ram_data; we_cnt++; end
      if (rx_rdy) last_rx_cyc = cyc;
      if (core_start) begin start_cnt++; start_cyc = cyc; end

      case (m_phase)
        0: begin
          sz = q.size();
          if (sz > 0) begin void'(q.pop_front()); m_pix++; end
          if (m_pix == NUM_BITS) begin
            if (rx_rdy || q.size() > 0) m_ov = 1;
            q.delete();
            m_phase = 1;
          end else if (rx_rdy) begin
            // One byte in flight plus a one-byte buffer.
            if (sz <= 9) begin
              if (sz == 0 && m_pix == 0) m_ov = 0;
              for (int b = 0; b < 8; b++) q.push_back(rx_data[b]);
            end else m_ov = 1;
          end
        end
        1: begin
          if (rx_rdy) m_ov = 1;
          m_pix = 0; m_phase = 2;
        end
        default: begin
          if (rx_rdy) m_ov = 1;
          if (core_done) m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    core_addr = ADDR_W'($urandom);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_rdy = 1'b1; rx_data = b;
    tick();
    rx_rdy = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
  endtask

  task automatic wait_start(input int s0, input string name);
    int n = 0;
    while (start_cnt == s0 && n < 40) begin tick(); n++; end
    check(name, int'(start_cnt != s0), 1);
  endtask

  task automatic finish_core();
    repeat ($urandom_range(1, 5)) tick();
    core_done = 1'b1; tick(); core_done = 1'b0; tick();
  endtask

  logic [7:0] img [0:NBYTES-1];

  initial begin
    int bad, s0, w0, tries;

    // Reset state
    repeat (3) tick();
    check("t1_we", ram_we, 0);
    check("t1_busy", busy, 0);
    check("t1_ovr", overrun, 0);
    check("t1_addr", ram_addr, 0);
    rst = 1'b0;
    tick();

    // Single byte A5: LSB first into addresses 0..7
    send_byte(8'hA5);
    repeat (10) tick();
    check("t2_bits", {tb_mem[7], tb_mem[6], tb_mem[5], tb_mem[4],
                      tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 8'hA5);
    check("t2_b0", tb_mem[0], 1);
    check("t2_b1", tb_mem[1], 0);
    check("t2_wecnt", we_cnt, 8);
    check("t2_model_pix", m_pix, 8);
    check("t2_busy", busy, 1);
    check("t2_nostart", start_cnt, 0);

    // Back-to-back bytes through the hold buffer, third one dropped
    do_reset();
    w0 = we_cnt;
    send_byte(8'h3C); tick(); tick();
    send_byte(8'hC3); tick(); tick();
    check("t4_ovr_before", overrun, 0);
    send_byte(8'hFF);
    repeat (16) tick();
    check("t4_wecnt", we_cnt - w0, 16);
    check("t4_byte1", {tb_mem[15], tb_mem[14], tb_mem[13], tb_mem[12],
                       tb_mem[11], tb_mem[10], tb_mem[9], tb_mem[8]}, 8'hC3);
    check("t4_ovr", overrun, 1);
    check("t4_model_pix", m_pix, 16);

    // Full frame spaced 100 cycles; start 9 cycles after last byte
    do_reset();
    for (int k = 0; k < NBYTES; k++) img[k] = 8'($urandom);
    s0 = start_cnt;
    for (int k = 0; k < NBYTES; k++) begin
      send_byte(img[k]);
      repeat (99) tick();
      if (k == NBYTES - 2) s0 = start_cnt;
    end
    check("t3_one_start", start_cnt - s0, 1);
    check("t3_latency", start_cyc - last_rx_cyc, 9);
    bad = 0;
    for (int a = 0; a < NUM_BITS; a++)
      if (tb_mem[a] != img[a/8][a%8]) bad++;
    check("t3_image_bits", bad, 0);
    check("t3_ovr", overrun, 0);

    // Byte while core runs: dropped, addr follows core
    w0 = we_cnt;
    send_byte(8'h5A);
    tick();
    core_addr = 10'h2A5; #1;
    check("t5_addr_core", ram_addr, 10'h2A5);
    check("t5_ovr", overrun, 1);
    check("t5_nowrite", we_cnt - w0, 0);
    finish_core();
    check("t5_idle_busy", busy, 0);
    send_byte(8'h0F);
    repeat (9) tick();
    check("t5_wecnt", we_cnt - w0, 8);
    check("t5_lowbits", {tb_mem[3], tb_mem[2], tb_mem[1], tb_mem[0]}, 4'hF);
    check("t5_ovr_clr", overrun, 0);

    // Reset in the middle of byte 50
    do_reset();
    for (int k = 0; k <= 50; k++) begin
      send_byte(8'($urandom));
      if (k < 50) repeat (9) tick();
    end
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("t6_async_we", ram_we, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_addr", ram_addr, 0);
    tick(); tick();
    rst = 1'b0;
    tick();
    s0 = start_cnt;
    for (int k = 0; k < NBYTES; k++) begin
      img[k] = 8'($urandom);
      send_byte(img[k]);
      repeat (7) tick();
    end
    wait_start(s0, "t6_start");
    bad = 0;
    for (int a = 0; a < NUM_BITS; a++)
      if (tb_mem[a] != img[a/8][a%8]) bad++;
    check("t6_image_bits", bad, 0);
    finish_core();

    // Random spacing frames, including drops, mid-run bytes and done timing
    for (int f = 0; f < 3; f++) begin
      s0 = start_cnt;
      tries = 0;
      while (start_cnt == s0 && tries < 600) begin
        send_byte(8'($urandom));
        repeat ($urandom_range(0, 12)) tick();
        tries++;
      end
      check("rnd_frame_started", int'(start_cnt != s0), 1);
      if ($urandom_range(0, 1) == 1) send_byte(8'($urandom));
      finish_core();
    end

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
